multi_digit_scan_display: RTL
=============================

// Module: multi_digit_scan_display
// PURPOSE
//  Parametrised N-digit time-multiplexed hex display driver for common-segment 7-seg modules.
//  Scans NUM_DIGITS digits in turn, with a programmable all-off blanking gap between digits (anti-ghosting).
//  Display value is double-buffered: load_i writes a shadow register, which commits atomically at a frame boundary.
//  Adds optional leading-zero suppression. Sits between user/keypad logic and the board segment/digit pins.
// PARAMETERS
//  NUM_DIGITS      4      digits scanned, legal 1..8; digit 0 = rightmost = value_i[3:0]
//  SCAN_DIV        48000  clk cycles each digit is lit, legal >= 2
//  BLANK_CYCLES    480    clk cycles all digits off between digits; 0 = no blank state
//  SEG_ACTIVE_LOW  1      1: segment lit when seg_o bit = 0 (dp_o likewise)
//  DIGIT_ACTIVE_LOW 1     1: digit powered when digit_o bit = 0
// PORTS
//  clk            in   1             system clock (48 MHz on board)
//  reset          in   1             asynchronous, active-low reset
//  value_i        in   4*NUM_DIGITS  hex nibbles, digit k = value_i[4k+3:4k]
//  dp_i           in   NUM_DIGITS    decimal point per digit
//  load_i         in   1             1-cycle strobe: capture value_i/dp_i into shadow
//  lz_suppress_i  in   1             1: blank leading zero digits
//  enable_i       in   1             0: all digits dark, scan timing continues
//  seg_o          out  7             segments {a,b,c,d,e,f,g} = bits [6:0]
//  dp_o           out  1             decimal point of the lit digit
//  digit_o        out  NUM_DIGITS    one-hot (at active level) digit power
//  frame_o        out  1             1-cycle pulse on every entry to digit 0 ON
//  pending_o      out  1             shadow holds uncommitted data
// BEHAVIOUR
//  - Reset (async assert, sync release): seg_o/dp_o/digit_o all inactive level, frame_o=0, pending_o=0;
//    shadow=active=0; FSM=BLANK, idx=NUM_DIGITS-1, counter=0.
//  - FSM states ON, BLANK. ON lasts SCAN_DIV cycles lighting digit idx; then BLANK for BLANK_CYCLES
//    (skipped if 0) with all digits off; leaving BLANK sets idx = (idx==NUM_DIGITS-1) ? 0 : idx+1, enters ON.
//  - Digit period = SCAN_DIV+BLANK_CYCLES; frame = NUM_DIGITS*period (defaults: 193920 cycles, ~247.5 Hz).
//  - All outputs registered, computed from next-state: they change on the same edge the FSM changes state.
//  - Commit: on the edge entering ON with idx=0, if pending_o then active<=shadow, pending_o<=0; frame_o=1
//    that cycle regardless of pending.
//  - load_i: shadow<=value_i/dp_i, pending_o<=1 next cycle. load_i on the commit edge: active gets the old
//    shadow, shadow takes the new value, pending_o stays 1 (commits next frame).
//  - Leading-zero suppression: digit k (k>=1) dark if its nibble and all higher nibbles in active are 0 and
//    lz_suppress_i=1; digit 0 never suppressed. Suppressed digit: digit_o inactive, dp_o still dark.
//  - enable_i=0: digit_o forced inactive from next edge; idx/counter/commit/frame_o unaffected.
//  - Segment pattern via shared decoder; polarity applied at output register only.
//  - Counter width $clog2(max(SCAN_DIV,BLANK_CYCLES)+1); elaboration error on illegal parameters.
// STRUCTURE
//  - display_pkg: seg_t (logic [6:0]), active-high hex font constants SEG_HEX[16], SEG_OFF, state enum
//    {ST_ON, ST_BLANK}.
//  - Sub-module hex_seg_decoder (4-bit nibble -> active-high seg_t, pure comb); one instance on selected nibble.
//  - Top: prescaler counter, FSM + idx, shadow/active registers, LZ mask comb, output registers.
// TESTING  (NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2, active-low both)
//  1 Reset low -> seg_o=7'h7F, digit_o=4'hF, frame_o=0, pending_o=0; release -> 2 cycles later
//    digit_o=4'b1110, frame_o=1 for 1 cycle, seg_o=~SEG_HEX[0].
//  2 Free run -> digit_o 1110 x8, 1111 x2, 1101 x8, 1111 x2, ...; frame_o period exactly 40 cycles.
//  3 load_i with value_i=16'h1A2F during digit 2 -> pending_o=1, digits 2,3 still show 0; at next frame_o
//    digit0 seg=~SEG_HEX[F], digit3 ~SEG_HEX[1], pending_o=0.
//  4 lz_suppress_i=1, committed 16'h0050 -> digits 3,2 never powered, digit1 '5', digit0 '0';
//    committed 16'h0000 -> only digit 0 lit ('0').
//  5 load_i 16'h1111 on commit edge with shadow 16'h2222 pending -> frame shows 2222, pending_o stays 1,
//    next frame shows 1111; enable_i=0 -> digit_o=4'hF next edge while frame_o keeps 40-cycle period.
//  6 Assert reset mid digit 2 between clk edges -> outputs inactive immediately (no edge), active value=0.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and the active-high hex font for the multiplexed 7-segment display driver.
package display_pkg;

  typedef logic [6:0] seg_t;

  typedef enum logic {
    ST_ON    = 1'b0,
    ST_BLANK = 1'b1
  } state_t;

  localparam seg_t SEG_OFF = 7'h00;

  // Segment order {a,b,c,d,e,f,g} = bits [6:0], 1 = segment lit.
  localparam seg_t SEG_HEX [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hex_seg_decoder.sv
// Pure combinational nibble to active-high segment pattern lookup.
module hex_seg_decoder
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg
);

  assign seg = SEG_HEX[nibble];

endmodule

// File: rtl/multi_digit_scan_display.sv
// N-digit time-multiplexed hex display driver with blanking gap, double-buffered value
// committed at frame start, and optional leading-zero suppression.
module multi_digit_scan_display
  import display_pkg::*;
#(
  parameter int NUM_DIGITS       = 4,
  parameter int SCAN_DIV         = 48000,
  parameter int BLANK_CYCLES     = 480,
  parameter bit SEG_ACTIVE_LOW   = 1'b1,
  parameter bit DIGIT_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic                    load_i,
  input  logic                    lz_suppress_i,
  input  logic                    enable_i,
  output logic [6:0]              seg_o,
  output logic                    dp_o,
  output logic [NUM_DIGITS-1:0]   digit_o,
  output logic                    frame_o,
  output logic                    pending_o
);

  localparam int CNT_W = $clog2(max_int(SCAN_DIV, BLANK_CYCLES) + 1);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] SCAN_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  localparam logic [6:0]            SEG_IDLE   = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic                  DP_IDLE    = SEG_ACTIVE_LOW;
  localparam logic [NUM_DIGITS-1:0] DIGIT_IDLE = DIGIT_ACTIVE_LOW ? '1 : '0;

  generate
    if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
      $error("multi_digit_scan_display: NUM_DIGITS must be 1..8");
    end
    if (SCAN_DIV < 2) begin : g_bad_scan
      $error("multi_digit_scan_display: SCAN_DIV must be >= 2");
    end
    if (BLANK_CYCLES < 0) begin : g_bad_blank
      $error("multi_digit_scan_display: BLANK_CYCLES must be >= 0");
    end
  endgenerate

  state_t                  state_reg, state_next;
  logic [IDX_W-1:0]        idx_reg, idx_next;
  logic [CNT_W-1:0]        cnt_reg, cnt_next;
  logic                    enter_on;
  logic                    commit;

  logic [4*NUM_DIGITS-1:0] shadow_val_reg, shadow_val_next;
  logic [NUM_DIGITS-1:0]   shadow_dp_reg, shadow_dp_next;
  logic [4*NUM_DIGITS-1:0] active_val_reg, active_val_next;
  logic [NUM_DIGITS-1:0]   active_dp_reg, active_dp_next;
  logic                    pending_reg, pending_next;

  logic [6:0]              seg_reg;
  logic                    dp_reg;
  logic [NUM_DIGITS-1:0]   digit_reg;
  logic                    frame_reg;

  logic [3:0]              nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   supp;
  logic [3:0]              nib_sel;
  seg_t                    seg_dec;
  logic                    lit;
  seg_t                    seg_hi;
  logic                    dp_hi;
  logic [NUM_DIGITS-1:0]   digit_hi;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_BLANK;
      idx_reg   <= IDX_LAST;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic; a zero-length blank goes straight from one digit to the next.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    cnt_next   = cnt_reg + CNT_W'(1);
    enter_on   = 1'b0;
    case (state_reg)
      ST_ON: begin
        if (cnt_reg == SCAN_LAST) begin
          cnt_next = '0;
          if (BLANK_CYCLES == 0) begin
            state_next = ST_ON;
            idx_next   = (idx_reg == IDX_LAST) ? '0 : idx_reg + IDX_W'(1);
            enter_on   = 1'b1;
          end else begin
            state_next = ST_BLANK;
          end
        end
      end
      default: begin
        if (BLANK_CYCLES == 0 || cnt_reg == BLANK_LAST) begin
          cnt_next   = '0;
          state_next = ST_ON;
          idx_next   = (idx_reg == IDX_LAST) ? '0 : idx_reg + IDX_W'(1);
          enter_on   = 1'b1;
        end
      end
    endcase
  end

  assign commit = enter_on && (idx_next == '0);

  // Buffer update: a load on the commit edge still lets the old shadow through first.
  always_comb begin
    shadow_val_next = shadow_val_reg;
    shadow_dp_next  = shadow_dp_reg;
    active_val_next = active_val_reg;
    active_dp_next  = active_dp_reg;
    pending_next    = pending_reg;
    if (commit && pending_reg) begin
      active_val_next = shadow_val_reg;
      active_dp_next  = shadow_dp_reg;
      pending_next    = 1'b0;
    end
    if (load_i) begin
      shadow_val_next = value_i;
      shadow_dp_next  = dp_i;
      pending_next    = 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign nib[gi] = active_val_next[4*gi +: 4];
      if (gi == 0) begin : g_first
        assign supp[gi] = 1'b0;
      end else begin : g_upper
        assign supp[gi] = lz_suppress_i && (active_val_next[4*NUM_DIGITS-1:4*gi] == '0);
      end
    end
  endgenerate

  assign nib_sel = nib[idx_next];

  hex_seg_decoder u_dec (
    .nibble (nib_sel),
    .seg    (seg_dec)
  );

  // Output values, active-high, derived from the upcoming state so they switch with it.
  always_comb begin
    lit      = (state_next == ST_ON) && enable_i && !supp[idx_next];
    seg_hi   = lit ? seg_dec : SEG_OFF;
    dp_hi    = lit && active_dp_next[idx_next];
    digit_hi = lit ? (NUM_DIGITS'(1) << idx_next) : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow_val_reg <= '0;
      shadow_dp_reg  <= '0;
      active_val_reg <= '0;
      active_dp_reg  <= '0;
      pending_reg    <= 1'b0;
      seg_reg        <= SEG_IDLE;
      dp_reg         <= DP_IDLE;
      digit_reg      <= DIGIT_IDLE;
      frame_reg      <= 1'b0;
    end else begin
      shadow_val_reg <= shadow_val_next;
      shadow_dp_reg  <= shadow_dp_next;
      active_val_reg <= active_val_next;
      active_dp_reg  <= active_dp_next;
      pending_reg    <= pending_next;
      seg_reg        <= SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;
      dp_reg         <= SEG_ACTIVE_LOW ? ~dp_hi : dp_hi;
      digit_reg      <= DIGIT_ACTIVE_LOW ? ~digit_hi : digit_hi;
      frame_reg      <= commit;
    end
  end

  assign seg_o     = seg_reg;
  assign dp_o      = dp_reg;
  assign digit_o   = digit_reg;
  assign frame_o   = frame_reg;
  assign pending_o = pending_reg;

endmodule
